// File: rtl/axi_rx_fifo_channel.sv
// ---------------------------------------------------------------------------
// AxiRxFifoChannel (module axi_rx_fifo_channel)
//
// Purpose:
//   Receive-side buffer between the slave AXI-lite W/AW path and the memory
//   write manager. Beats of {addr,data} arrive on a VALID/READY interface and
//   are queued in a DEPTH-entry FIFO. A two-state drain machine moves the head
//   of the FIFO into a registered output stage and presents it to memory with
//   a WE/BUSY handshake. The master can stream at one beat per cycle until the
//   FIFO fills; total capacity is DEPTH FIFO entries plus the output register.
//
// Ports:
//   ACLK         in   clock, all state on rising edge
//   ARESET       in   asynchronous active-high reset
//   S_VALID      in   beat offered by TX side
//   S_READY      out  beat can be accepted (combinational from registered count)
//   S_ADDR       in   beat address  [LEN_ADDR-1:0]
//   S_DATA       in   beat data     [LEN_DATA-1:0]
//   MEM_WE       out  output stage holds a beat for memory
//   MEM_ADDR     out  address of presented beat
//   MEM_DATA     out  data of presented beat
//   MEM_BUSY     in   memory cannot take a beat this cycle
//   LEVEL        out  FIFO occupancy, registered        (RX_FIFO_LEVEL_EN only)
//   ALMOST_FULL  out  LEVEL >= DEPTH-1, registered      (RX_FIFO_LEVEL_EN only)
//
// Build option:
//   RX_FIFO_LEVEL_EN  when defined, adds the LEVEL / ALMOST_FULL status ports.
// ---------------------------------------------------------------------------
module axi_rx_fifo_channel #(
    parameter int LEN_ADDR = 10,
    parameter int LEN_DATA = 32,
    parameter int DEPTH    = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       S_VALID,
    output logic                       S_READY,
    input  logic [LEN_ADDR-1:0]        S_ADDR,
    input  logic [LEN_DATA-1:0]        S_DATA,
`ifdef RX_FIFO_LEVEL_EN
    output logic [$clog2(DEPTH+1)-1:0] LEVEL,
    output logic                       ALMOST_FULL,
`endif
    output logic                       MEM_WE,
    output logic [LEN_ADDR-1:0]        MEM_ADDR,
    output logic [LEN_DATA-1:0]        MEM_DATA,
    input  logic                       MEM_BUSY
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int BEAT_W = LEN_ADDR + LEN_DATA;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } drainState_t;

    logic [BEAT_W-1:0] r_fifo [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    drainState_t       r_state;
    logic              r_memWe;
    logic [LEN_ADDR-1:0] r_memAddr;
    logic [LEN_DATA-1:0] r_memData;

    logic              w_push;
    logic              w_pop;
    logic              w_notEmpty;
    logic [CNT_W-1:0]  w_countNext;

    // The ready flag depends only on the registered count so that the TX side
    // never sees a combinational path from its own VALID back to READY. A pop
    // in the same cycle does not free a slot early: a full FIFO stays closed.
    assign S_READY    = !ARESET && (r_count != CNT_W'(DEPTH));
    assign w_push     = S_VALID && S_READY;
    assign w_notEmpty = (r_count != '0);

    // The head is popped whenever the output register is free to take it:
    // either nothing is presented yet, or the presented beat is leaving now.
    assign w_pop       = w_notEmpty && ((r_state == IDLE) || !MEM_BUSY);
    assign w_countNext = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Storage array carries no reset; entries are only read after being
    // written, and pointers/count are cleared so stale contents are never used.
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= {S_ADDR, S_DATA};
        end
    end

    // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
    // pointers wrap by plain binary overflow.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= w_countNext;
        end
    end

    // Drain machine with registered memory-side outputs. In PRESENT the beat
    // is held untouched while memory is busy; when it leaves, the next head is
    // loaded on the same edge so a full FIFO drains at one beat per cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_memWe   <= 1'b0;
            r_memAddr <= '0;
            r_memData <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        {r_memAddr, r_memData} <= r_fifo[r_rdPtr];
                        r_memWe <= 1'b1;
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (!MEM_BUSY) begin
                        if (w_pop) begin
                            {r_memAddr, r_memData} <= r_fifo[r_rdPtr];
                        end else begin
                            r_memWe <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_memWe <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign MEM_WE   = r_memWe;
    assign MEM_ADDR = r_memAddr;
    assign MEM_DATA = r_memData;

`ifdef RX_FIFO_LEVEL_EN
    logic [CNT_W-1:0] r_level;
    logic             r_almostFull;

    // Status registers track the FIFO occupancy only; the beat sitting in
    // the output register is not counted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_level      <= '0;
            r_almostFull <= 1'b0;
        end else begin
            r_level      <= w_countNext;
            r_almostFull <= (w_countNext >= CNT_W'(DEPTH-1));
        end
    end

    assign LEVEL       = r_level;
    assign ALMOST_FULL = r_almostFull;
`endif

endmodule

// File: tb/tb_axi_rx_fifo_channel.sv
// ---------------------------------------------------------------------------
// Testbench for axi_rx_fifo_channel. Stimulus tasks push expected beats into
// a scoreboard queue as they are accepted; a monitor process compares every
// presented memory beat against the queue head and pops on each transfer.
// ---------------------------------------------------------------------------
module tb_axi_rx_fifo_channel;

    localparam int LEN_ADDR = 10;
    localparam int LEN_DATA = 32;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = $clog2(DEPTH+1);

    logic                ACLK;
    logic                ARESET;
    logic                S_VALID;
    logic                S_READY;
    logic [LEN_ADDR-1:0] S_ADDR;
    logic [LEN_DATA-1:0] S_DATA;
    logic                MEM_WE;
    logic [LEN_ADDR-1:0] MEM_ADDR;
    logic [LEN_DATA-1:0] MEM_DATA;
    logic                MEM_BUSY;
`ifdef RX_FIFO_LEVEL_EN
    logic [CNT_W-1:0]    LEVEL;
    logic                ALMOST_FULL;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    int stallCount  = 0;
    int weRun       = 0;
    int maxWeRun    = 0;

    logic [LEN_ADDR+LEN_DATA-1:0] sbQ [$];

    axi_rx_fifo_channel #(
        .LEN_ADDR(LEN_ADDR),
        .LEN_DATA(LEN_DATA),
        .DEPTH   (DEPTH)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .S_VALID    (S_VALID),
        .S_READY    (S_READY),
        .S_ADDR     (S_ADDR),
        .S_DATA     (S_DATA),
`ifdef RX_FIFO_LEVEL_EN
        .LEVEL      (LEVEL),
        .ALMOST_FULL(ALMOST_FULL),
`endif
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DATA   (MEM_DATA),
        .MEM_BUSY   (MEM_BUSY)
    );

    // 10 ns clock
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Single comparison point: counts the check and reports a failure line.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer one beat and hold it until accepted; record the beat in the
    // scoreboard on the cycle it is taken. Waiting cycles are counted as stalls.
    task automatic applyStimulus(input logic [LEN_ADDR-1:0] addr,
                                 input logic [LEN_DATA-1:0] data);
        S_VALID = 1'b1;
        S_ADDR  = addr;
        S_DATA  = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (S_READY) begin
                sbQ.push_back({addr, data});
                @(posedge ACLK);
                #1;
                S_VALID = 1'b0;
                return;
            end
            stallCount++;
            @(posedge ACLK);
            #1;
        end
        checkOutput("push_timeout", 64'd0, 64'd1);
        S_VALID = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic waitDrained(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sbQ.size() == 0 && !MEM_WE) return;
            waitCycles(1);
        end
        checkOutput(name, 64'(sbQ.size()), 64'd0);
    endtask

    // Monitor: whatever is presented must match the expected head; a
    // transfer (WE && !BUSY) retires it. Also tracks runs of WE high.
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                weRun = 0;
            end else if (MEM_WE) begin
                weRun++;
                if (weRun > maxWeRun) maxWeRun = weRun;
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_beat", {22'd0, MEM_ADDR, MEM_DATA}, 64'd0);
                end else begin
                    checkOutput("mem_beat", {22'd0, MEM_ADDR, MEM_DATA}, {22'd0, sbQ[0]});
                    if (!MEM_BUSY) void'(sbQ.pop_front());
                end
            end else begin
                weRun = 0;
            end
        end
    end

    initial begin
        ARESET   = 1'b1;
        S_VALID  = 1'b0;
        S_ADDR   = '0;
        S_DATA   = '0;
        MEM_BUSY = 1'b0;

        // Reset state
        waitCycles(2);
        checkOutput("rst_we",    64'(MEM_WE),   64'd0);
        checkOutput("rst_addr",  64'(MEM_ADDR), 64'd0);
        checkOutput("rst_data",  64'(MEM_DATA), 64'd0);
        checkOutput("rst_ready", 64'(S_READY),  64'd0);
        ARESET = 1'b0;
        waitCycles(1);
        checkOutput("ready_after_rst", 64'(S_READY), 64'd1);

        // Reset mid-stream with 3 beats buffered: all are discarded
        $display("[TB] reset mid-stream");
        MEM_BUSY = 1'b1;
        applyStimulus(10'h3A1, 32'hBAD0_0001);
        applyStimulus(10'h3A2, 32'hBAD0_0002);
        applyStimulus(10'h3A3, 32'hBAD0_0003);
        ARESET = 1'b1;
        sbQ.delete();
        waitCycles(1);
        checkOutput("midrst_we",    64'(MEM_WE),  64'd0);
        checkOutput("midrst_ready", 64'(S_READY), 64'd0);
`ifdef RX_FIFO_LEVEL_EN
        checkOutput("midrst_level", 64'(LEVEL),   64'd0);
`endif
        ARESET   = 1'b0;
        MEM_BUSY = 1'b0;
        waitCycles(1);
        checkOutput("postrst_ready", 64'(S_READY), 64'd1);
        waitCycles(6);
        checkOutput("postrst_no_stale", 64'(MEM_WE), 64'd0);

        // Single beat latency
        $display("[TB] single beat");
        applyStimulus(10'h005, 32'hDEAD_BEEF);
        checkOutput("single_we_e",  64'(MEM_WE), 64'd0);
        waitCycles(1);
        checkOutput("single_we_e1", 64'(MEM_WE), 64'd1);
        checkOutput("single_addr",  64'(MEM_ADDR), 64'h005);
        checkOutput("single_data",  64'(MEM_DATA), 64'hDEAD_BEEF);
        waitCycles(1);
        checkOutput("single_we_e2", 64'(MEM_WE), 64'd0);
        waitDrained("single_drain");

        // Streaming 8 beats back-to-back
        $display("[TB] streaming");
        stallCount = 0;
        maxWeRun   = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(LEN_ADDR'(10'h100 + i), LEN_DATA'(i));
        end
        waitDrained("stream_drain");
        checkOutput("stream_stalls", 64'(stallCount), 64'd0);
        checkOutput("stream_we_run", 64'(maxWeRun),   64'd8);

        // Fill: 5 accepted while memory is busy, 6th waits
        $display("[TB] full");
        MEM_BUSY   = 1'b1;
        stallCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(LEN_ADDR'(10'h200 + i), LEN_DATA'(32'hF000_0000 + i));
`ifdef RX_FIFO_LEVEL_EN
            if (i == 3) begin
                checkOutput("full_level3", 64'(LEVEL),       64'd3);
                checkOutput("full_af3",    64'(ALMOST_FULL), 64'd1);
            end
`endif
        end
        checkOutput("full_stalls5", 64'(stallCount), 64'd0);
        S_VALID = 1'b1;
        S_ADDR  = 10'h205;
        S_DATA  = 32'hF000_0005;
        @(negedge ACLK);
        checkOutput("full_ready6", 64'(S_READY), 64'd0);
`ifdef RX_FIFO_LEVEL_EN
        checkOutput("full_level4", 64'(LEVEL),       64'd4);
        checkOutput("full_af4",    64'(ALMOST_FULL), 64'd1);
`endif
        @(posedge ACLK);
        #1;
        fork
            applyStimulus(10'h205, 32'hF000_0005);
            begin
                waitCycles(3);
                MEM_BUSY = 1'b0;
            end
        join
        checkOutput("full_6th_waited", 64'(stallCount > 0), 64'd1);
        waitDrained("full_drain");

        // Simultaneous push and transfer with count=2; pointers cross 3->0
        $display("[TB] simultaneous");
        MEM_BUSY = 1'b1;
        applyStimulus(10'h301, 32'h0000_3001);
        applyStimulus(10'h302, 32'h0000_3002);
        applyStimulus(10'h303, 32'h0000_3003);
        MEM_BUSY = 1'b0;
        applyStimulus(10'h304, 32'h0000_3004);
        MEM_BUSY = 1'b1;
`ifdef RX_FIFO_LEVEL_EN
        checkOutput("simul_level", 64'(LEVEL), 64'd2);
`endif
        checkOutput("simul_ready", 64'(S_READY), 64'd1);
        waitCycles(1);
        MEM_BUSY = 1'b0;
        waitDrained("simul_drain");

        // Busy stall pattern 1,0,1,1,0 while presenting A then B
        $display("[TB] busy stall");
        MEM_BUSY = 1'b1;
        applyStimulus(10'h0AA, 32'hAAAA_AAAA);
        applyStimulus(10'h0BB, 32'hBBBB_BBBB);
        waitCycles(1);
        checkOutput("stall_we", 64'(MEM_WE), 64'd1);
        MEM_BUSY = 1'b1; waitCycles(1);
        MEM_BUSY = 1'b0; waitCycles(1);
        checkOutput("stall_b_addr", 64'(MEM_ADDR), 64'h0BB);
        MEM_BUSY = 1'b1; waitCycles(1);
        MEM_BUSY = 1'b1; waitCycles(1);
        checkOutput("stall_b_held", 64'(MEM_DATA), 64'hBBBB_BBBB);
        MEM_BUSY = 1'b0; waitCycles(1);
        checkOutput("stall_idle", 64'(MEM_WE), 64'd0);
        checkOutput("stall_queue_empty", 64'(sbQ.size()), 64'd0);

        waitCycles(2);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
